toggle_fault_monitor: RTL
=========================

Name: toggle_fault_monitor

Overview:
Downstream checker for the toggling register array used in laser fault injection. Each cycle it predicts every register's next value from its previous value and enable, then flags mismatches. It records which registers faulted, when the first fault occurred, and how many faulting cycles were seen. It runs on the same clock as the array and reads the same enable vector the array sees.

Parameters:
N_REGS, 8, number of monitored registers; must be >= 2.
CNT_W, 16, width of the faulting-cycle counter.
TS_W, 32, width of the cycle timestamp.
HALT_ON_FIRST, 0, 1 = stop monitoring after the first faulting cycle.

Ports:
clk  input  1  system clock, shared with the register array.
reset  input  1  synchronous, active-high reset.
arm  input  1  single-cycle pulse; starts or restarts monitoring.
clear  input  1  single-cycle pulse; wipes results and returns to IDLE.
reg_en  input  N_REGS  per-register enable, the same synchronised signal that drives the array.
reg_q  input  N_REGS  register outputs under observation.
busy  output  1  high in SETTLE or MONITOR.
halted  output  1  high in HALTED.
fault_flag  output  1  high when fault_mask != 0.
fault_mask  output  N_REGS  sticky OR of all fault vectors since the last arm or clear.
first_idx  output  $clog2(N_REGS)  lowest faulting bit index in the first faulting cycle.
first_ts  output  TS_W  timestamp of the first faulting cycle.
fault_count  output  CNT_W  number of cycles with at least one fault; saturating.

Behaviour:
- History registers: q_prev <= reg_q and en_prev <= reg_en, updated every cycle in every state, including IDLE.
- Expected value per bit i: exp[i] = en_prev[i] ? ~q_prev[i] : 1'b0.
- Fault vector: fv = reg_q ^ exp. fv is evaluated only in MONITOR.
- States: IDLE, SETTLE, MONITOR, HALTED.
- IDLE: results hold their values. On arm, zero all results and ts, then go to SETTLE.
- SETTLE: lasts exactly 1 cycle, so that the history registers hold valid data. Then go to MONITOR with ts = 0.
- MONITOR: ts increments once per cycle and saturates at all-ones. On a cycle where fv != 0:
  - fault_mask |= fv.
  - fault_count increments by 1, saturating at 2^CNT_W-1.
  - If this is the first faulting cycle since arm, latch first_idx = lowest set bit of fv and first_ts = current ts.
  - If HALT_ON_FIRST = 1, go to HALTED. The faulting cycle itself is still recorded.
- MONITOR never leaves on its own when HALT_ON_FIRST = 0.
- HALTED: results frozen. arm restarts via SETTLE; clear goes to IDLE.
- Results are updated one cycle after the faulting sample, i.e. registered outputs with 1-cycle latency from reg_q.
- arm in SETTLE, MONITOR, or HALTED: zero all results and re-enter SETTLE.
- clear in any state: zero all results, go to IDLE. If clear and arm are asserted in the same cycle, clear wins.
- fault_flag is combinational from the fault_mask register.
- Multiple faulting bits in one cycle count as +1 for fault_count. first_idx takes the lowest index.
- reset: state = IDLE, all outputs and internal registers 0, q_prev = 0, en_prev = 0. Asserting reset mid-MONITOR discards all results.
- A disabled register held at 0 is correct. A disabled register reading 1 is a fault.
- Enabling a register from 0 produces the expected 0 -> 1 toggle with no false fault.

Test Plan:
- Model array (q <= en ? ~q : 0), reg_en = 8'hFF, arm, run 200 cycles -> fault_count 0, fault_mask 0, fault_flag 0, busy 1.
- Same setup, force reg_q[3] inverted for one cycle at ts 20 -> fault_mask 8'h08, first_idx 3, first_ts 20, fault_count 1. Overriding one cycle breaks the toggle chain, so also expect a second fault on bit 3 at ts 21 unless the model is resynced; the bench resyncs the model.
- reg_en = 8'h0F, force reg_q[6] = 1 for one cycle at ts 5, together with a flip of bit 2 in the same cycle -> fault_mask 8'h44, first_idx 2, first_ts 5, fault_count 1.
- CNT_W = 4, force reg_q[0] constantly wrong for 30 cycles -> fault_count saturates at 15 and holds; first_ts equals the first-fault ts.
- HALT_ON_FIRST = 1, fault at ts 7 -> halted 1, busy 0, first_ts 7, count 1. Further faults leave results unchanged. A subsequent arm -> results zeroed, SETTLE, then MONITOR.
- arm and clear asserted in the same cycle during MONITOR -> IDLE, all results 0. Separately, assert reset mid-MONITOR after 3 faults -> all outputs 0, IDLE.

Source files
------------

// File: rtl/toggle_fault_monitor.sv
// Checker for a toggling register array: predicts each register's next value from
// its previous value and enable, then records which registers faulted, when, and how often.

module toggle_fault_lane (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic q,
   output logic fv
);
   logic q_prev;
   logic en_prev;
   logic exp_q;

   // History is tracked in every state so it is valid by the time monitoring starts.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_prev  <= 1'b0;
         en_prev <= 1'b0;
      end else begin
         q_prev  <= q;
         en_prev <= en;
      end
   end

   // An enabled register must invert; a disabled one must read 0.
   assign exp_q = en_prev ? ~q_prev : 1'b0;
   assign fv    = q ^ exp_q;
endmodule

module toggle_fault_monitor #(
   parameter int N_REGS        = 8,
   parameter int CNT_W         = 16,
   parameter int TS_W          = 32,
   parameter bit HALT_ON_FIRST = 1'b0,
   localparam int IDX_W        = $clog2(N_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              arm,
   input  logic              clear,
   input  logic [N_REGS-1:0] reg_en,
   input  logic [N_REGS-1:0] reg_q,
   output logic              busy,
   output logic              halted,
   output logic              fault_flag,
   output logic [N_REGS-1:0] fault_mask,
   output logic [IDX_W-1:0]  first_idx,
   output logic [TS_W-1:0]   first_ts,
   output logic [CNT_W-1:0]  fault_count
);
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_MONITOR = 2'd2,
      S_HALTED  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              wipe;
   logic              hit;
   logic              first_seen;
   logic [TS_W-1:0]   ts;
   logic [N_REGS-1:0] fv_raw;
   logic [IDX_W-1:0]  low_idx;

   genvar gi;
   generate
      for (gi = 0; gi < N_REGS; gi++) begin : g_lane
         toggle_fault_lane u_lane (
            .clk   (clk),
            .reset (reset),
            .en    (reg_en[gi]),
            .q     (reg_q[gi]),
            .fv    (fv_raw[gi])
         );
      end
   endgenerate

   assign hit = (state == S_MONITOR) && (fv_raw != '0);

   // Descending scan so the lowest set bit is the one left standing.
   always_comb begin
      low_idx = '0;
      for (int i = N_REGS - 1; i >= 0; i--) begin
         if (fv_raw[i]) low_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wipe      = 1'b0;
      case (state)
         S_IDLE:    ;
         S_SETTLE:  state_nxt = S_MONITOR;
         S_MONITOR: if (HALT_ON_FIRST && hit) state_nxt = S_HALTED;
         S_HALTED:  ;
         default:   state_nxt = S_IDLE;
      endcase
      if (arm) begin
         state_nxt = S_SETTLE;
         wipe      = 1'b1;
      end
      // clear overrides a simultaneous arm
      if (clear) begin
         state_nxt = S_IDLE;
         wipe      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || wipe) begin
         ts          <= '0;
         first_seen  <= 1'b0;
         fault_mask  <= '0;
         first_idx   <= '0;
         first_ts    <= '0;
         fault_count <= '0;
      end else if (state == S_SETTLE) begin
         ts <= '0;
      end else if (state == S_MONITOR) begin
         if (ts != '1) ts <= ts + 1'b1;
         if (hit) begin
            fault_mask <= fault_mask | fv_raw;
            if (fault_count != '1) fault_count <= fault_count + 1'b1;
            if (!first_seen) begin
               first_seen <= 1'b1;
               first_idx  <= low_idx;
               first_ts   <= ts;
            end
         end
      end
   end

   assign busy       = (state == S_SETTLE) || (state == S_MONITOR);
   assign halted     = (state == S_HALTED);
   assign fault_flag = (fault_mask != '0);
endmodule
